regfile_onehot_wr: RTL and testbench

// - MIPS 32x32 general-purpose register file, directly downstream of the 5->32 decoder.
// - Consumes the decoder's one-hot output y[31:0] as its write-select; does not re-decode the address.
// - Provides two combinational read ports (rs, rt) with optional write-to-read bypass.
// - Checks each write-select for one-hot validity; a malformed select suppresses the write and is logged.

---
 rtl/mips_pkg.sv | 11 +
 rtl/onehot_enc.sv | 24 ++
 rtl/regfile_onehot_wr.sv | 78 +++++++
 tb/tb_regfile_onehot_wr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Imported by the register file and one-hot helpers.
package mips_pkg;
   localparam int NREGS  = 32;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [WIDTH-1:0]  word_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder.
// valid is set only when exactly one input bit is high.
module onehot_enc
   import mips_pkg::*;
#(
   parameter int N  = NREGS,
   parameter int AW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [AW-1:0] idx,
   output logic          valid
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = idx | AW'(i);
      end
   end

   // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
   assign valid = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/regfile_onehot_wr.sv
// MIPS register file written through a decoder one-hot select.
// Malformed selects drop the write and bump a saturating error count.
module regfile_onehot_wr
   import mips_pkg::*;
#(
   parameter int WIDTH  = mips_pkg::WIDTH,
   parameter int NREGS  = mips_pkg::NREGS,
   parameter int ADDR_W = $clog2(NREGS),
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [NREGS-1:0]  we_onehot,
   input  logic [WIDTH-1:0]  wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic              clr_err,
   output logic              err,
   output logic [7:0]        err_cnt
);

   logic [WIDTH-1:0]  mem [NREGS];
   logic [ADDR_W-1:0] wa;
   logic              sel_ok;
   logic              wr_ok;
   logic              bad;

   onehot_enc #(.N(NREGS), .AW(ADDR_W)) u_enc (
      .vec   (we_onehot),
      .idx   (wa),
      .valid (sel_ok)
   );

   assign wr_ok = we && sel_ok;
   assign bad   = we && !sel_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (wr_ok && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   // A new error on the clear edge restarts the count at one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err     <= 1'b0;
         err_cnt <= 8'd0;
      end else if (bad) begin
         err     <= 1'b1;
         if (clr_err)
            err_cnt <= 8'd1;
         else if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end else if (clr_err) begin
         err     <= 1'b0;
         err_cnt <= 8'd0;
      end
   end

   function automatic logic [WIDTH-1:0] rd_mux(input logic [ADDR_W-1:0] ra);
      logic [WIDTH-1:0] r;
      r = mem[ra];
      if (BYPASS && wr_ok && wa == ra) r = wd;
      if (ra == '0 || !rst) r = '0;
      return r;
   endfunction

   always_comb begin
      rd1 = rd_mux(ra1);
      rd2 = rd_mux(ra2);
   end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr: vector table,
// corner sequences and random traffic against an array model.
module tb_regfile_onehot_wr;
   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [31:0] we_onehot;
   logic [31:0] wd;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2;
   logic        clr_err;
   logic        err;
   logic [7:0]  err_cnt;

   int total = 0;
   int passed = 0;

   logic [31:0] m [32];
   bit          m_err;
   int          m_cnt;

   regfile_onehot_wr dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .we_onehot (we_onehot),
      .wd        (wd),
      .ra1       (ra1),
      .ra2       (ra2),
      .rd1       (rd1),
      .rd2       (rd2),
      .clr_err   (clr_err),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int ones(input logic [31:0] v);
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic int sel_idx(input logic [31:0] v);
      for (int i = 0; i < 32; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] ra);
      if (!rst || ra == 0) return 32'h0;
      if (we && ones(we_onehot) == 1 && sel_idx(we_onehot) == int'(ra))
         return wd;
      return m[ra];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      m_err = 0;
      m_cnt = 0;
   endtask

   // Apply one rising edge to both model and DUT.
   task automatic step();
      if (we && ones(we_onehot) == 1) begin
         if (sel_idx(we_onehot) != 0) m[sel_idx(we_onehot)] = wd;
      end
      if (we && ones(we_onehot) != 1) begin
         m_err = 1;
         m_cnt = clr_err ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      end else if (clr_err) begin
         m_err = 0;
         m_cnt = 0;
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] sel;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [31:0] exp_pre;
      logic [31:0] exp_post;
      logic        exp_err;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1, 32'h20, 32'hDEADBEEF, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
      tbl[1] = '{1, 32'h1, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 0};
      tbl[2] = '{1, 32'h30, 32'h11111111, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1};
      tbl[3] = '{1, 32'h30, 32'h22222222, 4, 32'h0, 32'h0, 1, 2};
      tbl[4] = '{0, 32'h0, 32'h5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 2};
      tbl[5] = '{0, 32'hFFFFFFFF, 32'h7, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 2};
      tbl[6] = '{1, 32'h0, 32'h9, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 3};
      tbl[7] = '{1, 32'h80, 32'h1234, 7, 32'h1234, 32'h1234, 1, 3};

      rst = 0; we = 0; we_onehot = 0; wd = 0;
      ra1 = 0; ra2 = 0; clr_err = 0;
      m_reset();
      #12;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         #1;
         check($sformatf("reset_rd1_%0d", a), rd1, 32'h0);
      end
      check("reset_err", {31'b0, err}, 32'h0);
      check("reset_cnt", {24'b0, err_cnt}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1;

      foreach (tbl[k]) begin
         we = tbl[k].we; we_onehot = tbl[k].sel; wd = tbl[k].wd;
         ra1 = tbl[k].ra; ra2 = tbl[k].ra;
         #2;
         check($sformatf("vec%0d_pre_rd1", k), rd1, tbl[k].exp_pre);
         check($sformatf("vec%0d_pre_rd2", k), rd2, tbl[k].exp_pre);
         step();
         we = 0;
         #1;
         check($sformatf("vec%0d_post_rd1", k), rd1, tbl[k].exp_post);
         check($sformatf("vec%0d_err", k), {31'b0, err}, {31'b0, tbl[k].exp_err});
         check($sformatf("vec%0d_cnt", k), {24'b0, err_cnt}, {24'b0, tbl[k].exp_cnt});
      end

      ra1 = 4; ra2 = 5;
      we = 1; we_onehot = 32'h30; wd = 32'hBAD0BAD0;
      for (int i = 0; i < 300; i++) step();
      we = 0;
      check("sat_cnt", {24'b0, err_cnt}, 32'd255);
      check("sat_err", {31'b0, err}, 32'h1);
      check("sat_reg4", rd1, 32'h0);
      check("sat_reg5", rd2, 32'hDEADBEEF);
      we = 1; clr_err = 1;
      step();
      check("clr_with_err_cnt", {24'b0, err_cnt}, 32'd1);
      check("clr_with_err_flag", {31'b0, err}, 32'h1);
      we = 0;
      step();
      clr_err = 0;
      check("clr_cnt", {24'b0, err_cnt}, 32'd0);
      check("clr_err", {31'b0, err}, 32'h0);

      ra1 = 7;
      #1;
      check("pre_rst_reg7", rd1, 32'h1234);
      we = 1; we_onehot = 32'h80; wd = 32'h5555;
      #2;
      rst = 0;
      m_reset();
      #1;
      check("rst_mid_rd1", rd1, 32'h0);
      @(posedge clk);
      #1;
      we = 0;
      rst = 1;
      #1;
      check("rst_after_reg7", rd1, 32'h0);
      we = 1; we_onehot = 32'h80; wd = 32'hABCD;
      step();
      we = 0;
      #1;
      check("resume_reg7", rd1, 32'hABCD);

      for (int a = 0; a < 32; a++) begin
         we = 1;
         we_onehot = 32'h1 << a;
         wd = 32'h1000_0000 + 32'(a);
         step();
      end
      we = 0;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a); ra2 = 5'(31 - a);
         #1;
         check($sformatf("sweep_rd1_%0d", a), rd1,
               a == 0 ? 32'h0 : 32'h1000_0000 + 32'(a));
         check($sformatf("sweep_model_%0d", a), rd2, m_rd(ra2));
      end
      check("sweep_err", {31'b0, err}, 32'h0);
      check("sweep_cnt", {24'b0, err_cnt}, 32'h0);

      for (int i = 0; i < 400; i++) begin
         we = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: we_onehot = $urandom;
            1: we_onehot = 32'h0;
            default: we_onehot = 32'h1 << $urandom_range(0, 31);
         endcase
         wd = $urandom;
         ra1 = 5'($urandom_range(0, 31));
         ra2 = ($urandom_range(0, 7) == 0) ? ra1 : 5'($urandom_range(0, 31));
         clr_err = ($urandom_range(0, 15) == 0);
         #2;
         check($sformatf("rnd%0d_rd1", i), rd1, m_rd(ra1));
         check($sformatf("rnd%0d_rd2", i), rd2, m_rd(ra2));
         step();
         check($sformatf("rnd%0d_err", i), {31'b0, err}, {31'b0, m_err});
         check($sformatf("rnd%0d_cnt", i), {24'b0, err_cnt}, 32'(m_cnt));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
